// File: rtl/nibble_serial_adder16_pkg.sv
// Shared definitions for the nibble-serial adder and the parallel adder wrappers.
// This file holds the controller state encodings and the slice width.
package nibble_serial_adder16_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder16_rca.sv
// 4-bit ripple-carry adder slice.
// The serial adder reuses this one slice for every nibble.
module rca_4bit
    import nibble_serial_adder16_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per cycle through a shared 4-bit slice.
// The carry between nibbles lives in carry_q; results are returned over a valid/ready handshake.
module nibble_serial_adder16
    import nibble_serial_adder16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB_W-1:0] a_nib, b_nib, slice_s;
    logic             slice_co;

    assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
    assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

    rca_4bit u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIB_W +: NIB_W] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // On the top nibble slice_s[3] is the final sum MSB.
                    cout_d  = slice_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIB_W-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Directed bench for nibble_serial_adder16: hand-computed vectors, backpressure,
// mid-operation reset and a randomised back-to-back stream against a reference model.
module tb_nibble_serial_adder16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair and return the number of cycles until out_valid rises.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          output int lat);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        step();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    function automatic res_t model(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        logic [16:0] full;
        res_t r;
        full = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
        r.s  = full[15:0];
        r.c  = full[16];
        r.o  = (av[15] == bv[15]) && (full[15] != av[15]);
        return r;
    endfunction

    initial begin
        int   lat;
        res_t q[$];
        res_t exp_r;
        int   accepted;
        int   received;
        int   cyc;
        logic fire_in, fire_out;
        logic [15:0] ra, rb;
        logic rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        step();

        // 1: plain add, latency
        launch(16'h1234, 16'h4321, 1'b0, lat);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_sum", 32'(sum), 32'h5555);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        pop("t1");

        // 2: carry through every nibble
        launch(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("t2_lat", 32'(lat), 32'd4);
        chk("t2_sum", 32'(sum), 32'h0000);
        chk("t2_cout", 32'(cout), 32'd1);
        chk("t2_ovf", 32'(ovf), 32'd0);
        pop("t2");

        // 3: signed overflow both directions
        launch(16'h7FFF, 16'h0001, 1'b0, lat);
        chk("t3a_sum", 32'(sum), 32'h8000);
        chk("t3a_cout", 32'(cout), 32'd0);
        chk("t3a_ovf", 32'(ovf), 32'd1);
        pop("t3a");
        launch(16'h8000, 16'h8000, 1'b0, lat);
        chk("t3b_sum", 32'(sum), 32'h0000);
        chk("t3b_cout", 32'(cout), 32'd1);
        chk("t3b_ovf", 32'(ovf), 32'd1);
        pop("t3b");

        // 4: cin, backpressure, ignored in_valid while busy
        launch(16'h0FFF, 16'h0000, 1'b1, lat);
        chk("t4_lat", 32'(lat), 32'd4);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_sum", 32'(sum), 32'h1000);
            chk("t4_hold_cout", 32'(cout), 32'd0);
            chk("t4_hold_ovf", 32'(ovf), 32'd0);
            chk("t4_hold_ov", 32'(out_valid), 32'd1);
            chk("t4_hold_ir", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("t4_sum_after", 32'(sum), 32'h1000);
        pop("t4");
        chk("t4_not_taken", 32'(sum), 32'h1000);
        step();
        chk("t4_still_idle", 32'(out_valid), 32'd0);

        // 5: reset during the second RUN cycle
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_ir", 32'(in_ready), 32'd1);
        chk("t5_ov", 32'(out_valid), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_partial", 32'(out_valid), 32'd0);
            step();
        end
        launch(16'h0001, 16'h0001, 1'b0, lat);
        chk("t5_lat", 32'(lat), 32'd4);
        chk("t5_sum2", 32'(sum), 32'h0002);
        pop("t5");

        // 6: back-to-back stream with random consumer stalls
        accepted = 0;
        received = 0;
        cyc      = 0;
        while (received < 50 && cyc < 5000) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            in_valid  = (accepted < 50);
            a = ra; b = rb; cin = rc;
            out_ready = 1'($urandom);
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (q.size() == 0) begin
                    chk("t6_spurious", 32'(1), 32'(0));
                end else begin
                    exp_r = q.pop_front();
                    chk("t6_sum", 32'(sum), 32'(exp_r.s));
                    chk("t6_cout", 32'(cout), 32'(exp_r.c));
                    chk("t6_ovf", 32'(ovf), 32'(exp_r.o));
                end
                received++;
            end
            if (fire_in) begin
                q.push_back(model(ra, rb, rc));
                accepted++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_received", 32'(received), 32'd50);
        chk("t6_queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
